instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles imem_req may wait for imem_ack.
REQ-003 SHALL have a single clock and a synchronous active-high reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 imem_req  out  1  instruction memory read request.
REQ-007 imem_addr  out  32  read address, equal to pc.
REQ-008 imem_ack  in  1  memory response; imem_rdata valid in the same cycle.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 instr  out  32  registered instruction word.
REQ-011 instr_valid  out  1  instr is valid for decode.
REQ-012 instr_ready  in  1  downstream accepts (retires) instr this cycle.
REQ-013 op  out  6  instr[31:26]; funct  out  6  instr[5:0] (decoder inputs).
REQ-014 branch, zero, jump  in  1 each  control/ALU feedback for the current instr.
REQ-015 pc  out  32  address of current instr; pc_plus4  out  32  pc+4.
REQ-016 fetch_err  out  1  sticky memory-timeout flag.
REQ-017 retired_cnt  out  32  retired instruction count (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, REQ, HOLD, ERR.
REQ-019 IDLE: all request and valid outputs low; next state REQ.
REQ-020 REQ: imem_req=1 and imem_addr=pc held stable; on imem_ack=1, instr<=imem_rdata and next state HOLD.
REQ-021 Latency: ack in the first REQ cycle SHALL give instr_valid=1 on the next cycle.
REQ-022 imem_ack SHALL be ignored outside REQ.
REQ-023 HOLD: instr_valid=1 and instr stable until instr_ready=1.
REQ-024 On HOLD with instr_ready=1: pc<=next_pc and next state REQ; instr_valid drops for at least one cycle.
REQ-025 next_pc priority: jump -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch&zero -> pc_plus4 + (signext(instr[15:0])<<2); else pc_plus4.
REQ-026 branch, zero and jump SHALL only be sampled in the HOLD&instr_ready cycle.
REQ-027 32-bit PC arithmetic SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 -> 0).
REQ-028 Wait counter SHALL clear on entering REQ and increment each REQ cycle without ack.
REQ-029 The wait counter reaching TIMEOUT_CYCLES without ack SHALL cause: fetch_err<=1, state ERR, imem_req=0.
REQ-030 ERR SHALL be left only by reset; instr_valid=0 in ERR.

Reset
REQ-031 rst=1 at an edge SHALL set: pc=RESET_PC, instr=0, state IDLE, wait counter 0, fetch_err=0, retired_cnt=0.
REQ-032 Reset mid-REQ SHALL drop imem_req in the following cycle; a late imem_ack SHALL be ignored.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-034 Macro IFETCH_RETIRE_CNT_EN defined: retired_cnt SHALL increment by 1 on each HOLD&instr_ready cycle and wrap at 2^32.
REQ-035 Macro IFETCH_RETIRE_CNT_EN undefined: retired_cnt SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-036 Reset release with imem_ack=1 on the first REQ cycle and rdata=32'h2008_0005 -> imem_addr=0; instr_valid on the next cycle; op=6'h08, funct=6'h05.
REQ-037 HOLD with instr_ready=0 for 5 cycles -> instr and pc stable, no imem_req; ready=1 -> pc becomes 4.
REQ-038 pc=0x10, instr=32'h1000_FFFE, branch=1, zero=1, ready=1 -> next pc=0x0C; same with zero=0 -> pc=0x14.
REQ-039 pc=0x0040_0000, instr=32'h0810_0004, jump=1 and branch=1, zero=1 -> pc=0x0040_0010 (jump wins).
REQ-040 imem_ack held low with TIMEOUT_CYCLES=4 -> fetch_err=1 after 4 REQ cycles and imem_req=0; rst -> fetch_err=0, pc=RESET_PC.
REQ-041 With IFETCH_RETIRE_CNT_EN, 3 retired instructions -> retired_cnt=3; without the macro -> retired_cnt=0.

Source files
------------

// File: rtl/imem_if.sv
// Instruction-memory read port: one request/address out, one ack/data back.
interface imem_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, memory request/timeout, instruction hold for decode.
// Optional feature macro: IFETCH_RETIRE_CNT_EN builds the retired-instruction counter.
module instr_fetch #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   imem_if.master      imem,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err,
   output logic [31:0] retired_cnt
);

   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam int unsigned LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LAST_I);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              fetch_err_d;
   logic              load_instr;
   logic              retire;
   logic              imem_req_q;
   logic [31:0]       br_off;
   logic [31:0]       next_pc;

   // Next-state, wait counter and event decode
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      fetch_err_d = fetch_err;
      load_instr  = 1'b0;
      retire      = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = REQ;
            wait_d  = '0;
         end
         REQ: begin
            if (imem.imem_ack) begin
               state_d    = HOLD;
               load_instr = 1'b1;
            end else if (wait_q == WAIT_LAST) begin
               state_d     = ERR;
               fetch_err_d = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         HOLD: begin
            if (instr_ready) begin
               state_d = REQ;
               wait_d  = '0;
               retire  = 1'b1;
            end
         end
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   // Control feedback only matters on the retire cycle; jump outranks a taken branch
   always_comb begin
      br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
      if (jump)
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      else if (branch && zero)
         next_pc = pc_plus4 + br_off;
      else
         next_pc = pc_plus4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         pc          <= RESET_PC;
         pc_plus4    <= RESET_PC + 32'd4;
         instr       <= '0;
         instr_valid <= 1'b0;
         imem_req_q  <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         fetch_err   <= fetch_err_d;
         instr_valid <= (state_d == HOLD);
         imem_req_q  <= (state_d == REQ);
         if (load_instr)
            instr <= imem.imem_rdata;
         if (retire) begin
            pc       <= next_pc;
            pc_plus4 <= next_pc + 32'd4;
         end
      end
   end

   assign imem.imem_req  = imem_req_q;
   assign imem.imem_addr = pc;
   assign op             = instr[31:26];
   assign funct          = instr[5:0];

`ifdef IFETCH_RETIRE_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         retired_cnt <= '0;
      else if (retire)
         retired_cnt <= retired_cnt + 32'd1;
   end
`else
   assign retired_cnt = '0;
`endif

endmodule
